// File: rtl/hex_display_mux.sv
// Four-digit, time-multiplexed hex seven-segment driver with a per-frame input snapshot.
// Segments and grid are active-low; one digit is lit per REFRESH_DIV-cycle slot.
module hex_display_mux #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] hex_in,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  en_in,
    output logic [7:0]  hex_seg,
    output logic [3:0]  hex_grid,
    output logic        frame_tick
);

    localparam int               CNT_W    = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    typedef struct packed {
        logic [15:0] hex;
        logic [3:0]  dp;
        logic [3:0]  en;
    } snap_t;

    logic [CNT_W-1:0] cnt;
    logic [1:0]       idx;
    snap_t            shadow;
    logic             slot_end;
    logic             frame_end;
    logic [3:0]       cur_nibble;

    // Active-low a..g pattern; the dp bit is prepended by the caller.
    function automatic logic [6:0] decode(input logic [3:0] value);
        logic [6:0] seg;
        case (value)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    assign slot_end   = (cnt == CNT_LAST);
    assign frame_end  = slot_end && (idx == 2'd3);
    // NOTE: gated with Reset so the pulse never leaks out while the registers are still being cleared.
    assign frame_tick = frame_end && !Reset;
    assign cur_nibble = shadow.hex[{idx, 2'b00} +: 4];

    // NOTE: outputs are registered from the pre-edge idx/shadow, so the pins trail the scan state by one cycle.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt      <= '0;
            idx      <= '0;
            shadow   <= '0;
            hex_seg  <= 8'hFF;
            hex_grid <= 4'hF;
        end else begin
            cnt <= slot_end ? '0 : cnt + CNT_W'(1);
            if (slot_end) begin
                idx <= idx + 2'd1;
            end
            if (frame_end) begin
                shadow <= {hex_in, dp_in, en_in};
            end
            if (shadow.en[idx]) begin
                hex_grid <= ~(4'b0001 << idx);
                hex_seg  <= {~shadow.dp[idx], decode(cur_nibble)};
            end else begin
                hex_grid <= 4'hF;
                hex_seg  <= 8'hFF;
            end
        end
    end

endmodule
